// File: rtl/framebuffer_fill_arbiter.sv
// Framebuffer port-A owner: shares the port between CPU accesses and a linear fill engine.
// Ports: CPU request/ready with read-data valid pulse one cycle after a granted read;
// fill start/abort/busy/done; combinational framebuffer port-A drive; registered fbDataOut in.
module framebuffer_fill_arbiter #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 2048,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             cpuRequest,
  input  logic             cpuWrite,
  input  logic [AW-1:0]    cpuAddress,
  input  logic [WIDTH-1:0] cpuDataIn,
  output logic             cpuReady,
  output logic [WIDTH-1:0] cpuDataOut,
  output logic             cpuDataValid,
  input  logic             fillStart,
  input  logic [AW-1:0]    fillAddress,
  input  logic [AW:0]      fillCount,
  input  logic [WIDTH-1:0] fillValue,
  input  logic             fillAbort,
  output logic             fillBusy,
  output logic             fillDone,
  output logic [AW-1:0]    fbAddress,
  output logic [WIDTH-1:0] fbDataIn,
  output logic             fbWriteEnable,
  input  logic [WIDTH-1:0] fbDataOut
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic             enabled_q;
  logic             last_fill_q, last_fill_d;  // 1 = fill won the last granted cycle
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW:0]      rem_q, rem_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             done_q, done_d;
  logic             rd_vld_q;
  logic [WIDTH-1:0] rd_dat_q;

  logic             grant_cpu, grant_fill;
  logic [AW:0]      eff_count;

  assign eff_count = (fillCount > DEPTH_C) ? DEPTH_C : fillCount;

  always_comb begin
    state_d       = state_q;
    last_fill_d   = last_fill_q;
    ptr_d         = ptr_q;
    rem_d         = rem_q;
    val_d         = val_q;
    done_d        = 1'b0;
    grant_cpu     = 1'b0;
    grant_fill    = 1'b0;
    fbAddress     = '0;
    fbDataIn      = '0;
    fbWriteEnable = 1'b0;

    // Arbitration: in FILL with both sides asking, the loser of the last cycle wins.
    if (enabled_q) begin
      if (state_q == FILL) begin
        if (cpuRequest) begin
          grant_cpu  = last_fill_q;
          grant_fill = !last_fill_q;
        end else begin
          grant_fill = 1'b1;
        end
      end else begin
        grant_cpu = cpuRequest;
      end
    end

    if (grant_cpu) begin
      last_fill_d   = 1'b0;
      fbAddress     = cpuAddress;
      fbDataIn      = cpuDataIn;
      fbWriteEnable = cpuWrite;
    end else if (grant_fill) begin
      last_fill_d   = 1'b1;
      fbAddress     = ptr_q;
      fbDataIn      = val_q;
      fbWriteEnable = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // A start accompanied by an abort is dropped entirely.
        if (fillStart && !fillAbort) begin
          if (eff_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = FILL;
            ptr_d   = fillAddress;
            rem_d   = eff_count;
            val_d   = fillValue;
          end
        end
      end
      FILL: begin
        if (grant_fill) begin
          // Explicit wrap so non power-of-two depths stay in range.
          ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (AW+1)'(1)) begin
            state_d = IDLE;
            done_d  = !fillAbort;
          end
        end
        if (fillAbort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      enabled_q   <= 1'b0;
      last_fill_q <= 1'b1;
      ptr_q       <= '0;
      rem_q       <= '0;
      val_q       <= '0;
      done_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_dat_q    <= '0;
    end else begin
      state_q   <= state_d;
      enabled_q <= 1'b1;
      if (grant_cpu || grant_fill) last_fill_q <= last_fill_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      val_q     <= val_d;
      done_q    <= done_d;
      rd_vld_q  <= grant_cpu && !cpuWrite;
      if (rd_vld_q) rd_dat_q <= fbDataOut;
    end
  end

  assign cpuReady     = grant_cpu;
  assign cpuDataValid = rd_vld_q;
  // Framebuffer output is live during the valid cycle; hold the last read afterwards.
  assign cpuDataOut   = rd_vld_q ? fbDataOut : rd_dat_q;
  assign fillBusy     = (state_q == FILL);
  assign fillDone     = done_q;

endmodule

// File: tb/tb_framebuffer_fill_arbiter.sv
module tb_framebuffer_fill_arbiter;
  localparam int W  = 9;
  localparam int D  = 2048;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          resetN;
  logic          cpuRequest, cpuWrite;
  logic [AW-1:0] cpuAddress;
  logic [W-1:0]  cpuDataIn, cpuDataOut;
  logic          cpuReady, cpuDataValid;
  logic          fillStart, fillAbort, fillBusy, fillDone;
  logic [AW-1:0] fillAddress;
  logic [AW:0]   fillCount;
  logic [W-1:0]  fillValue;
  logic [AW-1:0] fbAddress;
  logic [W-1:0]  fbDataIn, fbDataOut;
  logic          fbWriteEnable;

  framebuffer_fill_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .resetN(resetN),
    .cpuRequest(cpuRequest), .cpuWrite(cpuWrite), .cpuAddress(cpuAddress),
    .cpuDataIn(cpuDataIn), .cpuReady(cpuReady), .cpuDataOut(cpuDataOut),
    .cpuDataValid(cpuDataValid),
    .fillStart(fillStart), .fillAddress(fillAddress), .fillCount(fillCount),
    .fillValue(fillValue), .fillAbort(fillAbort), .fillBusy(fillBusy), .fillDone(fillDone),
    .fbAddress(fbAddress), .fbDataIn(fbDataIn), .fbWriteEnable(fbWriteEnable),
    .fbDataOut(fbDataOut)
  );

  always #5 clk = ~clk;

  // Framebuffer port A: synchronous write, registered read-first output.
  logic [W-1:0] fb_mem [D];
  always @(posedge clk) begin
    if (fbWriteEnable) fb_mem[fbAddress] <= fbDataIn;
    fbDataOut <= fb_mem[fbAddress];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected fill writes {addr,data} and expected read data.
  logic [AW+W-1:0] wq[$];
  logic [W-1:0]    rdq[$];
  logic [W-1:0]    ref_mem [D];
  logic            prev_rd = 1'b0;

  always @(negedge clk) begin
    chk("rd_vld", cpuDataValid, prev_rd);
    if (cpuDataValid) begin
      if (rdq.size() == 0) chk("rd_extra", 32'(rdq.size()), 1);
      else chk("rd_data", cpuDataOut, rdq.pop_front());
    end
    prev_rd = 1'b0;
    if (cpuReady) begin
      chk("cpu_addr", fbAddress, cpuAddress);
      chk("cpu_we", fbWriteEnable, cpuWrite);
      if (cpuWrite) chk("cpu_wdat", fbDataIn, cpuDataIn);
      else begin
        rdq.push_back(ref_mem[cpuAddress]);
        prev_rd = 1'b1;
      end
    end else if (fbWriteEnable) begin
      if (wq.size() == 0) chk("fill_extra", 32'(wq.size()), 1);
      else chk("fill_wr", {fbAddress, fbDataIn}, wq.pop_front());
    end
  end

  task automatic cpu_access(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
    int n = 0;
    cpuWrite = w; cpuAddress = a; cpuDataIn = d; cpuRequest = 1'b1;
    if (w) ref_mem[a] = d;
    do begin
      @(negedge clk);
      n++;
    end while (!cpuReady && n < 50);
    if (!cpuReady) chk("cpu_timeout", cpuReady, 1);
    @(posedge clk); #1;
    cpuRequest = 1'b0;
  endtask

  task automatic fill_start(input logic [AW-1:0] a, input int cnt, input logic [W-1:0] v,
                            input int limit);
    int eff = (cnt > D) ? D : cnt;
    int p   = int'(a);
    if (limit < eff) eff = limit;
    for (int i = 0; i < eff; i++) begin
      wq.push_back({AW'(p), v});
      ref_mem[p] = v;
      p = (p == D - 1) ? 0 : p + 1;
    end
    fillAddress = a; fillCount = (AW+1)'(cnt); fillValue = v; fillStart = 1'b1;
    @(posedge clk); #1;
    fillStart = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!fillDone && cyc < 5000);
    chk({tag, "_done"}, fillDone, 1);
    chk({tag, "_busy"}, fillBusy, 0);
    @(posedge clk); #1;
    chk({tag, "_wq"}, 32'(wq.size()), 0);
  endtask

  initial begin
    int cyc;
    logic seen;
    for (int i = 0; i < D; i++) begin
      fb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    resetN = 1'b0; cpuRequest = 1'b1; cpuWrite = 1'b0; cpuAddress = '0; cpuDataIn = '0;
    fillStart = 1'b0; fillAbort = 1'b0; fillAddress = '0; fillCount = '0; fillValue = '0;

    // Reset state, with a CPU request already pending.
    repeat (2) @(negedge clk);
    chk("rst_rdy", cpuReady, 0);
    chk("rst_we", fbWriteEnable, 0);
    chk("rst_busy", fillBusy, 0);
    chk("rst_done", fillDone, 0);
    chk("rst_addr", fbAddress, 0);
    @(posedge clk); #1; resetN = 1'b1;
    @(negedge clk); chk("rdy_first", cpuReady, 0);
    @(negedge clk); chk("rdy_enabled", cpuReady, 1);
    @(posedge clk); #1; cpuRequest = 1'b0;

    // CPU write then read-back.
    cpu_access(1'b1, 11'h010, 9'h1A5);
    cpu_access(1'b0, 11'h010, 9'h000);
    @(negedge clk);
    chk("rd_pulse", cpuDataValid, 1);
    chk("rd_val", cpuDataOut, 9'h1A5);
    @(negedge clk);
    chk("rd_pulse_end", cpuDataValid, 0);
    chk("idle_addr", fbAddress, 0);
    chk("idle_din", fbDataIn, 0);
    @(posedge clk); #1;

    // Plain fill of 4; a second start while busy must be ignored.
    fill_start(11'h100, 4, 9'h0FF, D);
    fillAddress = 11'h700; fillCount = 12'd2; fillValue = 9'h055; fillStart = 1'b1;
    @(posedge clk); #1; fillStart = 1'b0;
    wait_done("fill4", cyc);
    chk("fill4_lat", 32'(cyc + 1), 5);
    @(negedge clk); chk("fill4_pulse", fillDone, 0);
    @(posedge clk); #1;

    // Fill of 8 with CPU reads held: strict alternation starting with fill.
    cpuAddress = 11'h010; cpuWrite = 1'b0; cpuRequest = 1'b1;
    fill_start(11'h200, 8, 9'h133, D);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("alt_fill", fbWriteEnable && !cpuReady, (i % 2) == 0);
      chk("alt_cpu", cpuReady, (i % 2) == 1);
      if (i == 15) begin
        chk("alt_done", fillDone, 1);
        chk("alt_busy", fillBusy, 0);
      end
    end
    @(posedge clk); #1; cpuRequest = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    chk("alt_wq", 32'(wq.size()), 0);

    // Address wrap, zero count, and count above DEPTH.
    fill_start(AW'(D - 2), 4, 9'h1C3, D);
    wait_done("wrap", cyc);
    chk("wrap_lat", 32'(cyc), 5);
    fill_start(11'h050, 0, 9'h1FF, D);
    wait_done("zero", cyc);
    chk("zero_lat", 32'(cyc), 1);
    fill_start(11'h005, 3000, 9'h0AA, D);
    wait_done("clamp", cyc);
    chk("clamp_lat", 32'(cyc), D + 1);

    // Abort in IDLE together with start: nothing happens.
    fillAddress = 11'h600; fillCount = 12'd3; fillStart = 1'b1; fillAbort = 1'b1;
    @(posedge clk); #1; fillStart = 1'b0; fillAbort = 1'b0;
    @(negedge clk);
    chk("startabort_busy", fillBusy, 0);
    chk("startabort_done", fillDone, 0);
    @(posedge clk); #1;

    // Abort during the 3rd write of a count-10 fill.
    fill_start(11'h300, 10, 9'h0C4, 3);
    @(posedge clk); #1;
    @(posedge clk); #1; fillAbort = 1'b1;
    @(posedge clk); #1; fillAbort = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    chk("abort_busy", fillBusy, 0);
    for (int i = 0; i < 5; i++) begin
      seen |= fillDone;
      @(negedge clk);
    end
    chk("abort_nodone", seen, 0);
    chk("abort_wq", 32'(wq.size()), 0);
    @(posedge clk); #1;

    // Reset in the middle of a fill: write stops at once, nothing resumes.
    fill_start(11'h400, 10, 9'h0E7, 2);
    @(posedge clk); #1;
    @(posedge clk); #1; resetN = 1'b0;
    #1;
    chk("rstmid_we", fbWriteEnable, 0);
    chk("rstmid_busy", fillBusy, 0);
    repeat (2) @(posedge clk);
    #1; resetN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen |= fillDone | fillBusy;
    end
    chk("rstmid_quiet", seen, 0);
    chk("rstmid_wq", 32'(wq.size()), 0);
    @(posedge clk); #1;
    fill_start(11'h410, 2, 9'h011, D);
    wait_done("post_rst", cyc);
    chk("post_rst_lat", 32'(cyc), 3);

    repeat (3) @(negedge clk);
    chk("end_rdq", 32'(rdq.size()), 0);
    chk("end_wq", 32'(wq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
